pri_enc_drain: RTL and testbench
================================

// Module: pri_enc_drain
// PURPOSE
//  Parametrised, registered successor of the 8-to-3 priority encoder. Captures an
//  N-bit request vector, then emits the index of every set bit, highest first,
//  one per accepted beat on a valid/ready output. Keeps EI/GS/EO semantics.
//  Sits between interrupt/request aggregation and the service sequencer.
// PARAMETERS
//  N   8             request vector width; legal range N >= 2
//  W   $clog2(N)     localparam, index width; not overridable
// PORTS
//  clk        in   1  sole clock; all state updates on rising edge
//  rst        in   1  synchronous, active-high reset
//  ei         in   1  enable input; low aborts and blocks capture
//  in_valid   in   1  request vector valid
//  in_ready   out  1  vector accepted on in_valid && in_ready
//  in_req     in   N  request vector; bit N-1 has highest priority
//  out_valid  out  1  out_idx valid
//  out_ready  in   1  consumer accepts the beat
//  out_idx    out  W  index of the highest pending bit
//  out_last   out  1  high when the current beat is the final pending bit
//  gs         out  1  group select; high while draining
//  eo         out  1  one-cycle pulse when an enabled capture is all-zero
// BEHAVIOUR
//  - Reset: state=IDLE, pending=0, in_ready=0 during reset, out_valid=0,
//    out_idx=0, out_last=0, gs=0, eo=0. rst overrides all other inputs.
//  - States: IDLE, DRAIN. Registered pending[N-1:0].
//  - IDLE: in_ready = ei. On capture with in_req!=0: pending<=in_req, go DRAIN.
//    On capture with in_req==0: eo=1 next cycle for exactly one cycle, stay IDLE.
//  - DRAIN: in_ready=0, out_valid=1, gs=1. out_idx = highest set bit of pending.
//    out_last = (popcount(pending)==1). Both are derived combinationally from
//    registered pending.
//  - Latency: capture at edge k -> out_valid=1 after edge k. Each accepted beat
//    clears its bit at that edge. Return to IDLE after the last beat, then one
//    bubble cycle with in_ready=1 before the next capture.
//  - out_valid stays high and out_idx stays stable while out_ready=0
//    (AXI-style: no retraction).
//  - ei low in DRAIN: pending<=0, go IDLE at the next edge. A beat presented in
//    that cycle is dropped, even if out_ready=1. No eo pulse.
//  - ei low in IDLE: in_ready=0, no capture, no eo.
//  - in_req may change while in DRAIN; it is ignored.
//  - Bit N-1 set with all others clear: single beat, idx=N-1, out_last=1.
//  - All N bits set: N beats, idx N-1 down to 0; out_last on idx 0 only.
// CONFIGURATION
//  PRI_ENC_COUNT_EN defined: adds output out_cnt [W:0], the popcount of
//    pending. It is 0 in IDLE and after reset. It decrements on each accepted
//    beat.
//  PRI_ENC_COUNT_EN undefined: port and logic absent; all other behaviour is
//    identical.
// STRUCTURE
//  - pri_enc_pkg: state enum (ST_IDLE, ST_DRAIN) and function f_idx_w(N)
//    (= $clog2(N)).
//  - Sub-module pri_enc_comb #(N): combinational highest-set-bit finder.
//    Outputs idx[W-1:0], any. Instanced once on pending.
//  - Top holds the FSM, the pending register, handshake logic and the optional
//    counter.
// TESTING
//  1 rst=1 for 3 cycles, then release -> all outputs 0; in_ready=1 with ei=1.
//  2 N=8, in_req=8'b1010_0100, out_ready=1 -> idx 7,5,2 on consecutive cycles;
//    out_last on 2; then IDLE.
//  3 in_req=8'h00 captured -> eo=1 for exactly one cycle, gs=0, out_valid=0.
//  4 in_req=8'hFF, out_ready toggling 1,0,1 -> idx held stable while
//    stalled; 8 beats total.
//  5 ei=0 mid-drain of 8'h81 after idx 7 -> idx 0 never emitted; IDLE next cycle.
//  6 N=16 with PRI_ENC_COUNT_EN, in_req=16'h8001 -> out_cnt 2,1,0; idx 15 then 0.

Source files
------------

// File: rtl/pri_enc_pkg.sv
// rtl/pri_enc_pkg.sv - shared state encoding and index-width helper for the priority drain
package pri_enc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  function automatic int f_idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/pri_enc_comb.sv
// rtl/pri_enc_comb.sv - combinational highest-set-bit finder over an N-bit vector
module pri_enc_comb
  import pri_enc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]            req,
  output logic [f_idx_w(N)-1:0]   idx,
  output logic                    any
);

  localparam int W = f_idx_w(N);

  // Ascending scan: the last hit overwrites earlier ones, so the highest set bit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pri_enc_drain.sv
// rtl/pri_enc_drain.sv - registered priority encoder draining set-bit indices highest first
// Optional out_cnt (popcount of pending) when PRI_ENC_COUNT_EN is defined.
module pri_enc_drain
  import pri_enc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ei,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            in_req,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [f_idx_w(N)-1:0]   out_idx,
  output logic                    out_last,
  output logic                    gs,
  output logic                    eo
`ifdef PRI_ENC_COUNT_EN
  ,
  output logic [f_idx_w(N):0]     out_cnt
`endif
);

  localparam int W = f_idx_w(N);
  localparam logic [N-1:0] ONE = N'(1);

  state_t         state;
  state_t         state_nx;
  logic [N-1:0]   pending;
  logic [N-1:0]   pending_nx;
  logic           eo_nx;
  logic [W-1:0]   top_idx;
  logic           top_any;
  logic           single;

  pri_enc_comb #(.N(N)) u_find (
    .req (pending),
    .idx (top_idx),
    .any (top_any)
  );

  // Exactly one bit left: clearing the lowest set bit leaves nothing.
  assign single = top_any && ((pending & (pending - ONE)) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pending <= '0;
      eo      <= 1'b0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      eo      <= eo_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    eo_nx      = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    gs         = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = ei && !rst;
        if (in_valid && in_ready) begin
          if (in_req != '0) begin
            pending_nx = in_req;
            state_nx   = ST_DRAIN;
          end else begin
            eo_nx = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        gs        = 1'b1;
        // Dropping ei aborts the drain; any beat on offer this cycle is discarded.
        if (!ei) begin
          pending_nx = '0;
          state_nx   = ST_IDLE;
        end else if (out_ready) begin
          pending_nx = pending & ~(ONE << top_idx);
          if (single) begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: begin
        state_nx   = ST_IDLE;
        pending_nx = '0;
      end
    endcase
  end

  assign out_idx  = out_valid ? top_idx : '0;
  assign out_last = out_valid && single;

`ifdef PRI_ENC_COUNT_EN
  always_comb begin
    out_cnt = '0;
    for (int i = 0; i < N; i++) begin
      out_cnt = out_cnt + (W+1)'(pending[i]);
    end
  end
`endif

endmodule

// File: tb/tb_pri_enc_drain.sv
// tb/tb_pri_enc_drain.sv - self-checking bench for pri_enc_drain (N=8 and N=16 instances)
module tb_pri_enc_drain;

  logic        clk;
  logic        rst;
  logic        ei, in_valid, in_ready, out_valid, out_ready, out_last, gs, eo;
  logic [7:0]  in_req;
  logic [2:0]  out_idx;
  logic        w_ei, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_last, w_gs, w_eo;
  logic [15:0] w_in_req;
  logic [3:0]  w_out_idx;
`ifdef PRI_ENC_COUNT_EN
  logic [3:0]  out_cnt;
  logic [4:0]  w_out_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  pri_enc_drain #(.N(8)) dut (
    .clk(clk), .rst(rst), .ei(ei), .in_valid(in_valid), .in_ready(in_ready),
    .in_req(in_req), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .gs(gs), .eo(eo)
`ifdef PRI_ENC_COUNT_EN
    , .out_cnt(out_cnt)
`endif
  );

  pri_enc_drain #(.N(16)) dut_w (
    .clk(clk), .rst(rst), .ei(w_ei), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_req(w_in_req), .out_valid(w_out_valid), .out_ready(w_out_ready), .out_idx(w_out_idx),
    .out_last(w_out_last), .gs(w_gs), .eo(w_eo)
`ifdef PRI_ENC_COUNT_EN
    , .out_cnt(w_out_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; ei = 1'b1; in_valid = 1'b1; in_req = 8'hA5; out_ready = 1'b1;
    w_ei = 1'b1; w_in_valid = 1'b0; w_in_req = 16'h0; w_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || gs !== 1'b0 || eo !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold: in_ready=%b out_valid=%b gs=%b eo=%b, want 0 0 0 0",
               in_ready, out_valid, gs, eo);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 3'd0 || out_last !== 1'b0 ||
        gs !== 1'b0 || eo !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: rdy=%b vld=%b idx=%0d last=%b gs=%b eo=%b, want 1 0 0 0 0 0",
               in_ready, out_valid, out_idx, out_last, gs, eo);
    end
    n_cmp++;
    if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0 || w_out_idx !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_wide: rdy=%b vld=%b idx=%0d, want 1 0 0", w_in_ready, w_out_valid, w_out_idx);
    end
  endtask

  // Captures v in the current (idle) cycle, then drains it against a list of set-bit indices.
  task automatic test_drain(input logic [7:0] v, input bit stall);
    int q[$];
    int cyc;
    q = {};
    for (int b = 7; b >= 0; b--) if (v[b]) q.push_back(b);
    @(negedge clk);
    ei = 1'b1; in_valid = 1'b1; in_req = v; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || gs !== 1'b0 || eo !== 1'b0) begin
      n_bad++;
      $display("FAIL capture_idle v=%h: rdy=%b vld=%b gs=%b eo=%b, want 1 0 0 0",
               v, in_ready, out_valid, gs, eo);
    end
    if (v == 8'h00) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_cmp++;
      if (eo !== 1'b1 || gs !== 1'b0 || out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL zero_eo: eo=%b gs=%b vld=%b, want 1 0 0", eo, gs, out_valid);
      end
      return;
    end
    cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      @(negedge clk);
      in_valid = 1'($urandom % 2);
      in_req   = 8'($urandom);
      if (stall) out_ready = 1'($urandom % 2);
      cyc++;
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || gs !== 1'b1 || in_ready !== 1'b0 || eo !== 1'b0 ||
          out_idx !== 3'(q[0]) || out_last !== (q.size() == 1)) begin
        n_bad++;
        $display("FAIL beat v=%h: vld=%b gs=%b rdy=%b eo=%b idx=%0d last=%b, want 1 1 0 0 %0d %b",
                 v, out_valid, gs, in_ready, eo, out_idx, out_last, q[0], q.size() == 1);
      end
`ifdef PRI_ENC_COUNT_EN
      n_cmp++;
      if (out_cnt !== 4'(q.size())) begin
        n_bad++;
        $display("FAIL beat_cnt v=%h: cnt=%0d, want %0d", v, out_cnt, q.size());
      end
`endif
      if (out_ready) void'(q.pop_front());
    end
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout v=%h: %0d beats left, want 0", v, q.size());
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    ei = 1'b1; in_valid = 1'b1; in_req = 8'h81; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 3'd7) begin
      n_bad++;
      $display("FAIL abort_first: vld=%b idx=%0d, want 1 7", out_valid, out_idx);
    end
    @(negedge clk);
    ei = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_present: vld=%b idx=%0d rdy=%b, want 1 0 0", out_valid, out_idx, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b1; in_req = 8'hFF;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || gs !== 1'b0 || eo !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle: vld=%b gs=%b eo=%b rdy=%b, want 0 0 0 0", out_valid, gs, eo, in_ready);
    end
    @(negedge clk);
    ei = 1'b1; in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || eo !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ei_low_no_capture: vld=%b eo=%b rdy=%b, want 0 0 1", out_valid, eo, in_ready);
    end
  endtask

  task automatic test_wide();
    int exp_idx[2] = '{15, 0};
    @(negedge clk);
    w_in_valid = 1'b1; w_in_req = 16'h8001; w_out_ready = 1'b1;
    #1;
    n_cmp++;
    if (w_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL wide_ready: rdy=%b, want 1", w_in_ready);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      w_in_valid = 1'b0;
      #1;
      n_cmp++;
      if (w_out_valid !== 1'b1 || w_out_idx !== 4'(exp_idx[k]) || w_out_last !== (k == 1)) begin
        n_bad++;
        $display("FAIL wide_beat%0d: vld=%b idx=%0d last=%b, want 1 %0d %b",
                 k, w_out_valid, w_out_idx, w_out_last, exp_idx[k], k == 1);
      end
`ifdef PRI_ENC_COUNT_EN
      n_cmp++;
      if (w_out_cnt !== 5'(2 - k)) begin
        n_bad++;
        $display("FAIL wide_cnt%0d: cnt=%0d, want %0d", k, w_out_cnt, 2 - k);
      end
`endif
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (w_out_valid !== 1'b0 || w_gs !== 1'b0 || w_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL wide_done: vld=%b gs=%b rdy=%b, want 0 0 1", w_out_valid, w_gs, w_in_ready);
    end
`ifdef PRI_ENC_COUNT_EN
    n_cmp++;
    if (w_out_cnt !== 5'd0) begin
      n_bad++;
      $display("FAIL wide_cnt_idle: cnt=%0d, want 0", w_out_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    for (int t = 0; t < 40; t++) begin
      v = 8'($urandom);
      if ($urandom % 4 == 0) v = 8'h00;
      test_drain(v, 1'($urandom % 2));
    end
  endtask

  initial begin
    test_reset();
    test_drain(8'b1010_0100, 1'b0);
    test_drain(8'h00, 1'b0);
    test_drain(8'hFF, 1'b1);
    test_drain(8'h80, 1'b0);
    test_drain(8'hFF, 1'b0);
    test_abort();
    test_wide();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
